// File: rtl/key_expand_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key-expansion sequencer.
package key_expand_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OUT     = 2'd1,
    ST_EXPAND  = 2'd2,
    ST_SUBWAIT = 2'd3
  } state_t;

  localparam int unsigned NR_AES128     = 10;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned KEY_W         = 128;
  localparam logic [7:0]  AES_RCON_INIT = 8'h01;
  localparam logic [7:0]  XTIME_POLY    = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 is the multiplicative inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] base;
    logic [7:0] inv;
    base = x;
    inv  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      base = gf_mul(base, base);
      inv  = gf_mul(inv, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: S-box applied independently to each byte of a 32-bit word.
module aes_subword
  import key_expand_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/key_expand_ctrl_step.sv
// key_word_step: next-word compute for one in-place expansion step, plus the
// SubWord input mux (RotWord(w3) on idx0 only, zero otherwise).
module key_word_step
  import key_expand_ctrl_pkg::*;
(
  input  logic        i_en,
  input  logic [1:0]  i_idx,
  input  logic [31:0] i_w_prev,
  input  logic [31:0] i_w_cur,
  input  logic [31:0] i_w3,
  input  logic [7:0]  i_rcon,
  input  logic [31:0] i_subword,
  output logic [31:0] o_sub_in,
  output logic [31:0] o_w_next
);

  always_comb begin
    o_sub_in = '0;
    if (i_en && (i_idx == 2'd0)) o_sub_in = {i_w3[23:0], i_w3[31:24]};
  end

  always_comb begin
    if (i_idx == 2'd0) o_w_next = i_w_cur ^ i_subword ^ {i_rcon, 24'h0};
    else               o_w_next = i_w_cur ^ i_w_prev;
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key-expansion sequencer streaming 11 round keys over valid/ready.
// Optional macro KEY_EXPAND_SUBWORD_REG_EN registers the SubWord output (6 cycles/round).
module key_expand_ctrl
  import key_expand_ctrl_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("key_expand_ctrl: only NR=10 (AES-128) is supported");
  end

`ifdef KEY_EXPAND_SUBWORD_REG_EN
  localparam state_t ST_FIRST = ST_SUBWAIT;
`else
  localparam state_t ST_FIRST = ST_EXPAND;
`endif

  state_t       r_state, w_state_nx;
  logic [127:0] r_win, w_win_nx;
  logic [3:0]   r_round, w_round_nx;
  logic [1:0]   r_idx, w_idx_nx;
  logic [7:0]   r_rcon, w_rcon_nx;
  logic         r_done, w_done_nx;

  logic [31:0]  w_cur, w_prev, w_sub_in, w_sub_out, w_sub_use, w_word_nx;

  always_comb begin
    w_cur  = '0;
    w_prev = '0;
    unique case (r_idx)
      2'd0: begin w_cur = r_win[127:96]; w_prev = r_win[31:0];   end
      2'd1: begin w_cur = r_win[95:64];  w_prev = r_win[127:96]; end
      2'd2: begin w_cur = r_win[63:32];  w_prev = r_win[95:64];  end
      2'd3: begin w_cur = r_win[31:0];   w_prev = r_win[63:32];  end
      default: ;
    endcase
  end

  key_word_step u_step (
    .i_en      ((r_state == ST_EXPAND) || (r_state == ST_SUBWAIT)),
    .i_idx     (r_idx),
    .i_w_prev  (w_prev),
    .i_w_cur   (w_cur),
    .i_w3      (r_win[31:0]),
    .i_rcon    (r_rcon),
    .i_subword (w_sub_use),
    .o_sub_in  (w_sub_in),
    .o_w_next  (w_word_nx)
  );

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

`ifdef KEY_EXPAND_SUBWORD_REG_EN
  logic [31:0] r_sub;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sub <= '0;
    else        r_sub <= w_sub_out;
  end
  assign w_sub_use = r_sub;
`else
  assign w_sub_use = w_sub_out;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_win_nx   = r_win;
    w_round_nx = r_round;
    w_idx_nx   = r_idx;
    w_rcon_nx  = r_rcon;
    w_done_nx  = 1'b0;
    // abort overrides start, handshake and expansion progress alike
    if (abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_win_nx   = key;
            w_round_nx = '0;
            w_rcon_nx  = AES_RCON_INIT;
            w_state_nx = ST_OUT;
          end
        end
        ST_OUT: begin
          if (rk_ready) begin
            if (r_round == 4'(NR)) begin
              w_state_nx = ST_IDLE;
              w_done_nx  = 1'b1;
            end else begin
              w_idx_nx   = '0;
              w_state_nx = ST_FIRST;
            end
          end
        end
        ST_SUBWAIT: w_state_nx = ST_EXPAND;
        ST_EXPAND: begin
          unique case (r_idx)
            2'd0: w_win_nx[127:96] = w_word_nx;
            2'd1: w_win_nx[95:64]  = w_word_nx;
            2'd2: w_win_nx[63:32]  = w_word_nx;
            2'd3: w_win_nx[31:0]   = w_word_nx;
            default: ;
          endcase
          if (r_idx == 2'd3) begin
            w_round_nx = r_round + 4'd1;
            w_rcon_nx  = xtime(r_rcon);
            w_state_nx = ST_OUT;
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_round <= '0;
      r_idx   <= '0;
      r_rcon  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_win   <= w_win_nx;
      r_round <= w_round_nx;
      r_idx   <= w_idx_nx;
      r_rcon  <= w_rcon_nx;
      r_done  <= w_done_nx;
    end
  end

  // rk is masked outside OUT so a half-updated window is never visible
  assign rk_valid = (r_state == ST_OUT);
  assign rk       = rk_valid ? r_win : '0;
  assign rk_round = r_round;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl: FIPS-197 schedule table plus corner-case sequences.
module tb_key_expand_ctrl;

`ifdef KEY_EXPAND_SUBWORD_REG_EN
  localparam int CPR = 6;
`else
  localparam int CPR = 5;
`endif

  logic         clk, rst_n, start, abort, rk_ready, rk_valid, busy, done;
  logic [127:0] key, rk;
  logic [3:0]   rk_round;

  key_expand_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_round(rk_round),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] rk;
    int           cyc;
  } vec_t;

  vec_t tbl[11];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;
  int   inj_cycle = -1;
  int   t0;
  int   a;
  bit   ok;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZK_R1    = 128'h62636363626363636263636362636363;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cnt++;
    if (inj_cycle >= 0) begin
      if (cnt == inj_cycle) begin
        start = 1'b1;
        key   = '0;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(output bit found);
    int n;
    n = 0;
    while (!rk_valid && n < 40) begin
      step();
      n++;
    end
    found = rk_valid;
  endtask

  task automatic do_start(input logic [127:0] k, output int ts);
    key   = k;
    start = 1'b1;
    ts    = cnt;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Consume all 11 round keys with rk_ready high; ends in the done cycle.
  task automatic consume_all(input int ts, input bit timing);
    bit found;
    for (int i = 0; i < 11; i++) begin
      wait_valid(found);
      if (!found) begin
        chk("timeout_valid", 128'd0, 128'd1);
        return;
      end
      chk($sformatf("rk_r%0d", i), rk, tbl[i].rk);
      chk($sformatf("rk_round_r%0d", i), 128'(rk_round), 128'(tbl[i].round));
      if (timing) chk($sformatf("cycle_r%0d", i), 128'(cnt), 128'(ts + tbl[i].cyc));
      step();
    end
    chk("done_pulse", 128'(done), 128'd1);
    chk("busy_after_done", 128'(busy), 128'd0);
    if (timing) chk("done_cycle", 128'(cnt), 128'(ts + tbl[10].cyc + 1));
  endtask

  initial begin
    tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 0};
    tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 0};
    tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 0};
    tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 0};
    tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 0};
    tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 0};
    tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 0};
    tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 0};
    tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 0};
    tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 0};
    tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0};
    for (int i = 0; i < 11; i++) tbl[i].cyc = 1 + CPR * i;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b1; key = '0;
    step(); step();
    chk("reset_rk_valid", 128'(rk_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_rk", rk, 128'd0);
    chk("reset_rk_round", 128'(rk_round), 128'd0);
    rst_n = 1'b1;
    step();

    // FIPS schedule with exact timing, then zero-gap restart from the done cycle
    do_start(FIPS_KEY, t0);
    consume_all(t0, 1'b1);
    do_start('0, t0);
    chk("b2b_done_cleared", 128'(done), 128'd0);
    chk("b2b_r0_valid", 128'(rk_valid), 128'd1);
    chk("b2b_r0", rk, 128'd0);
    step();
    wait_valid(ok);
    chk("b2b_r1", rk, ZK_R1);
    chk("b2b_r1_round", 128'(rk_round), 128'd1);
    do_abort();

    // Backpressure at round 3
    do_start(FIPS_KEY, t0);
    for (int n = 0; n < 60 && !(rk_valid && rk_round == 4'd3); n++) step();
    rk_ready = 1'b0;
    for (int n = 0; n < 7; n++) begin
      chk($sformatf("bp_valid_%0d", n), 128'(rk_valid), 128'd1);
      chk($sformatf("bp_rk_%0d", n), rk, tbl[3].rk);
      chk($sformatf("bp_round_%0d", n), 128'(rk_round), 128'd3);
      step();
    end
    rk_ready = 1'b1;
    a = cnt;
    step();
    wait_valid(ok);
    chk("bp_r4_cycle", 128'(cnt), 128'(a + CPR));
    chk("bp_r4", rk, tbl[4].rk);
    do_abort();
    step();

    // start pulsed with key=0 during expansion must be ignored
    do_start(FIPS_KEY, t0);
    inj_cycle = t0 + 10;
    consume_all(t0, 1'b1);
    inj_cycle = -1;
    start = 1'b0;
    step();

    // abort coinciding with the round-2 handshake
    do_start(FIPS_KEY, t0);
    for (int n = 0; n < 60 && !(rk_valid && rk_round == 4'd2); n++) step();
    chk("ab_pre_round", 128'(rk_round), 128'd2);
    do_abort();
    chk("ab_valid", 128'(rk_valid), 128'd0);
    chk("ab_busy", 128'(busy), 128'd0);
    chk("ab_done", 128'(done), 128'd0);
    step();
    chk("ab_done_late", 128'(done), 128'd0);
    do_start('0, t0);
    chk("ab_new_r0", rk, 128'd0);
    step();
    wait_valid(ok);
    chk("ab_new_r1", rk, ZK_R1);
    do_abort();

    // asynchronous reset mid-EXPAND
    do_start(FIPS_KEY, t0);
    step();
    chk("rst_pre_busy", 128'(busy), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 128'(rk_valid), 128'd0);
    chk("rst_async_busy", 128'(busy), 128'd0);
    chk("rst_async_rk", rk, 128'd0);
    chk("rst_async_round", 128'(rk_round), 128'd0);
    @(posedge clk);
    #1;
    cnt++;
    rst_n = 1'b1;
    step();
    do_start(FIPS_KEY, t0);
    chk("rst_r0_valid", 128'(rk_valid), 128'd1);
    chk("rst_r0", rk, tbl[0].rk);
    chk("rst_r0_round", 128'(rk_round), 128'd0);
    do_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
